// File: rtl/multi_commit_rob_pkg.sv
// Shared constants and the per-entry payload type for the multi-commit reorder buffer.
// REG_SEL and ADDR_LEN are fixed machine-wide widths; the *_DEF values are the
// default sizing of the ROB itself.
package multi_commit_rob_pkg;

   localparam int REG_SEL          = 5;
   localparam int ADDR_LEN         = 32;
   localparam int ROB_DEPTH_DEF    = 64;
   localparam int DP_WIDTH_DEF     = 2;
   localparam int FIN_PORTS_DEF    = 5;
   localparam int COMMIT_WIDTH_DEF = 2;

   // Data carried by each entry from dispatch to retirement (no reset needed)
   typedef struct packed {
      logic                dstvalid;
      logic [REG_SEL-1:0]  dst;
      logic [ADDR_LEN-1:0] pc;
   } rob_payload_t;

endpackage

// File: rtl/multi_commit_rob_commit_select.sv
// rob_commit_select: prefix-AND over the ready bits of head..head+COMMIT_WIDTH-1.
// A slot may retire only if every older slot in the window retires too, so the
// number of retirements equals the length of the leading run of ready bits.
module rob_commit_select #(
   parameter int COMMIT_WIDTH = 2,
   parameter int NUM_W        = $clog2(COMMIT_WIDTH + 1)
) (
   input  logic [COMMIT_WIDTH-1:0] ready_i,
   output logic [COMMIT_WIDTH-1:0] valid_o,
   output logic [NUM_W-1:0]        num_o
);

   // Leading-run mask and its population count
   always_comb begin
      valid_o    = '0;
      num_o      = '0;
      valid_o[0] = ready_i[0];
      for (int j = 1; j < COMMIT_WIDTH; j++) begin
         valid_o[j] = ready_i[j] & valid_o[j-1];
      end
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         num_o = num_o + NUM_W'(valid_o[j]);
      end
   end

endmodule

// File: rtl/multi_commit_rob.sv
// multi_commit_rob: reorder buffer with multi-slot dispatch, multi-port completion
// and in-order multi-slot retirement. ROB index doubles as the RRF tag.
// Optional feature: define ROB_FLUSH_EN to build the flush_i/flush_tag_i squash path.
module multi_commit_rob
   import multi_commit_rob_pkg::*;
#(
   parameter int ROB_DEPTH    = ROB_DEPTH_DEF,
   parameter int DP_WIDTH     = DP_WIDTH_DEF,
   parameter int FIN_PORTS    = FIN_PORTS_DEF,
   parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
   parameter int ROB_SEL      = $clog2(ROB_DEPTH),
   parameter int NUM_W        = $clog2(COMMIT_WIDTH + 1)
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [DP_WIDTH-1:0]              dp_valid_i,
   input  logic [DP_WIDTH-1:0]              dp_dstvalid_i,
   input  logic [DP_WIDTH*REG_SEL-1:0]      dp_dst_i,
   input  logic [DP_WIDTH*ADDR_LEN-1:0]     dp_pc_i,
   output logic [DP_WIDTH*ROB_SEL-1:0]      dp_tag_o,
   output logic                             dp_ready_o,
   output logic [ROB_SEL:0]                 free_cnt_o,
   input  logic [FIN_PORTS-1:0]             fin_valid_i,
   input  logic [FIN_PORTS*ROB_SEL-1:0]     fin_tag_i,
   output logic [COMMIT_WIDTH-1:0]          com_valid_o,
   output logic [COMMIT_WIDTH*ROB_SEL-1:0]  com_tag_o,
   output logic [COMMIT_WIDTH-1:0]          com_arfwe_o,
   output logic [COMMIT_WIDTH*REG_SEL-1:0]  com_dst_o,
   output logic [NUM_W-1:0]                 com_num_o
`ifdef ROB_FLUSH_EN
  ,input  logic                             flush_i,
   input  logic [ROB_SEL-1:0]               flush_tag_i
`endif
);

   localparam logic [ROB_SEL:0] PTR_ONE = (ROB_SEL+1)'(1);

   // Pointers carry an extra wrap bit so full and empty are distinguishable
   logic [ROB_SEL:0]      head_q, head_d;
   logic [ROB_SEL:0]      tail_q, tail_d;
   logic [ROB_SEL:0]      free_cnt_q, free_cnt_d;
   logic [ROB_DEPTH-1:0]  valid_q, valid_d;
   logic [ROB_DEPTH-1:0]  done_q, done_d;
   rob_payload_t          payload_q [ROB_DEPTH];

   logic [ROB_SEL-1:0]    head_idx, tail_idx;
   logic [ROB_SEL-1:0]    dp_idx  [DP_WIDTH];
   logic [ROB_SEL-1:0]    com_idx [COMMIT_WIDTH];
   logic [ROB_SEL:0]      dp_cnt;
   logic                  dp_accept;
   logic [COMMIT_WIDTH-1:0] com_ready;
   logic [NUM_W-1:0]      com_num;

`ifdef ROB_FLUSH_EN
   logic                  flush_take;
   logic [ROB_SEL-1:0]    flush_dist;

   // A flush only counts when its surviving tag is live; distance is measured from head
   always_comb begin
      flush_take = flush_i & valid_q[flush_tag_i];
      flush_dist = flush_tag_i - head_idx;
   end
`endif

   assign head_idx = head_q[ROB_SEL-1:0];
   assign tail_idx = tail_q[ROB_SEL-1:0];

   // Dispatch slot tags and all-or-nothing acceptance against the registered free count
   always_comb begin
      dp_cnt   = '0;
      dp_tag_o = '0;
      for (int k = 0; k < DP_WIDTH; k++) begin
         dp_idx[k] = tail_idx + ROB_SEL'(k);
         dp_tag_o[k*ROB_SEL +: ROB_SEL] = dp_idx[k];
         dp_cnt = dp_cnt + (ROB_SEL+1)'(dp_valid_i[k]);
      end
      dp_accept = (dp_cnt != '0) && (dp_cnt <= free_cnt_q);
`ifdef ROB_FLUSH_EN
      if (flush_take) dp_accept = 1'b0;
`endif
   end

   // Ready bits of the commit window, cut at the flush point when squashing
   always_comb begin
      com_ready = '0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         com_idx[j]   = head_idx + ROB_SEL'(j);
         com_ready[j] = valid_q[com_idx[j]] & done_q[com_idx[j]];
`ifdef ROB_FLUSH_EN
         if (flush_take && (ROB_SEL'(j) > flush_dist)) com_ready[j] = 1'b0;
`endif
      end
   end

   rob_commit_select #(
      .COMMIT_WIDTH (COMMIT_WIDTH),
      .NUM_W        (NUM_W)
   ) u_commit_select (
      .ready_i (com_ready),
      .valid_o (com_valid_o),
      .num_o   (com_num)
   );

   assign com_num_o = com_num;

   // Commit outputs; tag and destination are zeroed on idle slots
   always_comb begin
      com_tag_o   = '0;
      com_dst_o   = '0;
      com_arfwe_o = '0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         if (com_valid_o[j]) begin
            com_tag_o[j*ROB_SEL +: ROB_SEL] = com_idx[j];
            com_dst_o[j*REG_SEL +: REG_SEL] = payload_q[com_idx[j]].dst;
            com_arfwe_o[j]                  = payload_q[com_idx[j]].dstvalid;
         end
      end
   end

   // Pointer and free-count next state
   always_comb begin
      head_d = head_q + (ROB_SEL+1)'(com_num);
      tail_d = tail_q;
      if (dp_accept) tail_d = tail_q + dp_cnt;
`ifdef ROB_FLUSH_EN
      if (flush_take) tail_d = head_q + (ROB_SEL+1)'(flush_dist) + PTR_ONE;
`endif
      free_cnt_d = (ROB_SEL+1)'(ROB_DEPTH) - (tail_d - head_d);
   end

   // Entry status next state: finish, then retire, then squash, then allocate
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      for (int p = 0; p < FIN_PORTS; p++) begin
         if (fin_valid_i[p] && valid_q[fin_tag_i[p*ROB_SEL +: ROB_SEL]]) begin
            done_d[fin_tag_i[p*ROB_SEL +: ROB_SEL]] = 1'b1;
         end
      end
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         if (com_valid_o[j]) begin
            valid_d[com_idx[j]] = 1'b0;
            done_d[com_idx[j]]  = 1'b0;
         end
      end
`ifdef ROB_FLUSH_EN
      if (flush_take) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            if ((ROB_SEL'(i) - head_idx) > flush_dist) begin
               valid_d[i] = 1'b0;
               done_d[i]  = 1'b0;
            end
         end
      end
`endif
      if (dp_accept) begin
         for (int k = 0; k < DP_WIDTH; k++) begin
            if (dp_valid_i[k]) begin
               valid_d[dp_idx[k]] = 1'b1;
               done_d[dp_idx[k]]  = 1'b0;
            end
         end
      end
   end

   // Control state registers with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         free_cnt_q <= (ROB_SEL+1)'(ROB_DEPTH);
         valid_q    <= '0;
         done_q     <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         free_cnt_q <= free_cnt_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
      end
   end

   // Payload storage, written only on accepted dispatch slots
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < DP_WIDTH; k++) begin
         if (dp_accept && dp_valid_i[k]) begin
            payload_q[dp_idx[k]] <= '{dstvalid: dp_dstvalid_i[k],
                                      dst:      dp_dst_i[k*REG_SEL +: REG_SEL],
                                      pc:       dp_pc_i[k*ADDR_LEN +: ADDR_LEN]};
         end
      end
   end

   assign free_cnt_o = free_cnt_q;
   assign dp_ready_o = free_cnt_q >= (ROB_SEL+1)'(DP_WIDTH);

   // Dispatch slots must be packed from bit 0
   a_dp_contiguous: assert property (@(posedge clk_i) disable iff (!reset_i)
      ((dp_valid_i & (dp_valid_i + DP_WIDTH'(1))) == '0));

endmodule

// File: tb/tb_multi_commit_rob.sv
// Directed, table-driven bench for multi_commit_rob (default sizing: 64 entries,
// 2 dispatch, 5 finish ports, 2 commit). The flush sequence is built only when
// ROB_FLUSH_EN is defined.
module tb_multi_commit_rob;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [1:0]  dp_valid_i, dp_dstvalid_i;
   logic [9:0]  dp_dst_i;
   logic [63:0] dp_pc_i;
   logic [11:0] dp_tag_o;
   logic        dp_ready_o;
   logic [6:0]  free_cnt_o;
   logic [4:0]  fin_valid_i;
   logic [29:0] fin_tag_i;
   logic [1:0]  com_valid_o, com_arfwe_o;
   logic [11:0] com_tag_o;
   logic [9:0]  com_dst_o;
   logic [1:0]  com_num_o;
   logic [5:0]  ftag [5];
`ifdef ROB_FLUSH_EN
   logic        flush_i;
   logic [5:0]  flush_tag_i;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   always_comb begin
      for (int p = 0; p < 5; p++) fin_tag_i[p*6 +: 6] = ftag[p];
   end

   multi_commit_rob dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .dp_valid_i    (dp_valid_i),
      .dp_dstvalid_i (dp_dstvalid_i),
      .dp_dst_i      (dp_dst_i),
      .dp_pc_i       (dp_pc_i),
      .dp_tag_o      (dp_tag_o),
      .dp_ready_o    (dp_ready_o),
      .free_cnt_o    (free_cnt_o),
      .fin_valid_i   (fin_valid_i),
      .fin_tag_i     (fin_tag_i),
      .com_valid_o   (com_valid_o),
      .com_tag_o     (com_tag_o),
      .com_arfwe_o   (com_arfwe_o),
      .com_dst_o     (com_dst_o),
      .com_num_o     (com_num_o)
`ifdef ROB_FLUSH_EN
     ,.flush_i       (flush_i),
      .flush_tag_i   (flush_tag_i)
`endif
   );

   typedef struct {
      logic [1:0] dpv, dpdv;
      logic [4:0] d0, d1;
      logic [4:0] finv;
      logic [5:0] ft0, ft1;     // port 1 uses ft1, all other ports use ft0
      logic [1:0] e_cv;
      logic [5:0] e_t0, e_t1;
      logic [1:0] e_we;
      logic [4:0] e_d0;
      logic [1:0] e_num;
      logic [6:0] e_free;
      logic       e_rdy;
      logic [5:0] e_dpt0;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_in();
      dp_valid_i    = '0;
      dp_dstvalid_i = '0;
      dp_dst_i      = '0;
      fin_valid_i   = '0;
      for (int p = 0; p < 5; p++) ftag[p] = '0;
`ifdef ROB_FLUSH_EN
      flush_i     = 1'b0;
      flush_tag_i = '0;
`endif
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      #2;
      step();
      reset_i = 1'b1;
   endtask

   initial begin
      reset_i = 1'b0;
      dp_pc_i = 64'h0000_1004_0000_1000;
      idle_in();

      //                 dpv    dpdv   d0 d1 finv      ft0 ft1  cv     t0 t1 we     d0 num   free rdy dpt0
      vecs[0]  = '{2'b11, 2'b11, 1, 2, 5'b00000, 0, 0,  2'b00, 0, 0, 2'b00, 0, 2'd0, 62, 1, 2};
      vecs[1]  = '{2'b00, 2'b00, 0, 0, 5'b00011, 0, 1,  2'b11, 0, 1, 2'b11, 1, 2'd2, 62, 1, 2};
      vecs[2]  = '{2'b00, 2'b00, 0, 0, 5'b00000, 0, 0,  2'b00, 0, 0, 2'b00, 0, 2'd0, 64, 1, 2};
      vecs[3]  = '{2'b11, 2'b11, 3, 4, 5'b00000, 0, 0,  2'b00, 0, 0, 2'b00, 0, 2'd0, 62, 1, 4};
      vecs[4]  = '{2'b00, 2'b00, 0, 0, 5'b00010, 0, 3,  2'b00, 0, 0, 2'b00, 0, 2'd0, 62, 1, 4};
      vecs[5]  = '{2'b00, 2'b00, 0, 0, 5'b01001, 2, 0,  2'b11, 2, 3, 2'b11, 3, 2'd2, 62, 1, 4};
      vecs[6]  = '{2'b00, 2'b00, 0, 0, 5'b00000, 0, 0,  2'b00, 0, 0, 2'b00, 0, 2'd0, 64, 1, 4};
      vecs[7]  = '{2'b01, 2'b00, 7, 0, 5'b00000, 0, 0,  2'b00, 0, 0, 2'b00, 0, 2'd0, 63, 1, 5};
      vecs[8]  = '{2'b00, 2'b00, 0, 0, 5'b00110, 4, 9,  2'b01, 4, 0, 2'b00, 7, 2'd1, 63, 1, 5};
      vecs[9]  = '{2'b00, 2'b00, 0, 0, 5'b00000, 0, 0,  2'b00, 0, 0, 2'b00, 0, 2'd0, 64, 1, 5};
      vecs[10] = '{2'b11, 2'b10, 5, 6, 5'b00000, 0, 0,  2'b00, 0, 0, 2'b00, 0, 2'd0, 62, 1, 7};
      vecs[11] = '{2'b00, 2'b00, 0, 0, 5'b00011, 5, 6,  2'b11, 5, 6, 2'b10, 5, 2'd2, 62, 1, 7};
      vecs[12] = '{2'b00, 2'b00, 0, 0, 5'b00000, 0, 0,  2'b00, 0, 0, 2'b00, 0, 2'd0, 64, 1, 7};

      // Reset state
      repeat (2) step();
      chk("rst_free",  free_cnt_o, 64);
      chk("rst_ready", dp_ready_o, 1);
      chk("rst_dptag", dp_tag_o, {6'd1, 6'd0});
      chk("rst_cv",    com_valid_o, 0);
      chk("rst_ctag",  com_tag_o, 0);
      chk("rst_cnum",  com_num_o, 0);
      chk("rst_cwe",   com_arfwe_o, 0);
      chk("rst_cdst",  com_dst_o, 0);
      reset_i = 1'b1;

      // Table: basic commit, out-of-order finish, dstvalid=0, invalid-tag finish
      for (int i = 0; i < 13; i++) begin
         dp_valid_i    = vecs[i].dpv;
         dp_dstvalid_i = vecs[i].dpdv;
         dp_dst_i      = {vecs[i].d1, vecs[i].d0};
         fin_valid_i   = vecs[i].finv;
         for (int p = 0; p < 5; p++) ftag[p] = (p == 1) ? vecs[i].ft1 : vecs[i].ft0;
         step();
         chk($sformatf("v%0d_cv", i),   com_valid_o,       vecs[i].e_cv);
         chk($sformatf("v%0d_t0", i),   com_tag_o[5:0],    vecs[i].e_t0);
         chk($sformatf("v%0d_t1", i),   com_tag_o[11:6],   vecs[i].e_t1);
         chk($sformatf("v%0d_we", i),   com_arfwe_o,       vecs[i].e_we);
         chk($sformatf("v%0d_d0", i),   com_dst_o[4:0],    vecs[i].e_d0);
         chk($sformatf("v%0d_num", i),  com_num_o,         vecs[i].e_num);
         chk($sformatf("v%0d_free", i), free_cnt_o,        vecs[i].e_free);
         chk($sformatf("v%0d_rdy", i),  dp_ready_o,        vecs[i].e_rdy);
         chk($sformatf("v%0d_dpt0", i), dp_tag_o[5:0],     vecs[i].e_dpt0);
      end
      idle_in();

      // Asynchronous reset while a commit is being presented
      dp_valid_i = 2'b11; dp_dstvalid_i = 2'b11;
      step();
      idle_in();
      fin_valid_i = 5'b00011; ftag[0] = 7; ftag[1] = 8;
      step();
      idle_in();
      chk("pre_arst_cv", com_valid_o, 2'b11);
      reset_i = 1'b0;
      #2;
      chk("arst_cv",   com_valid_o, 0);
      chk("arst_free", free_cnt_o, 64);
      chk("arst_dpt",  dp_tag_o, {6'd1, 6'd0});
      step();
      reset_i = 1'b1;

      // Fill to 64, drop dispatches while full, wrap on first free entry
      dp_valid_i = 2'b11; dp_dstvalid_i = 2'b11;
      for (int i = 0; i < 32; i++) step();
      chk("full_free",  free_cnt_o, 0);
      chk("full_ready", dp_ready_o, 0);
      chk("full_dpt0",  dp_tag_o[5:0], 0);
      dp_valid_i = 2'b01; fin_valid_i = 5'b00001; ftag[0] = 0;
      step();
      fin_valid_i = '0;
      chk("fullA_free", free_cnt_o, 0);
      chk("fullA_cv",   com_valid_o, 2'b01);
      chk("fullA_ctag", com_tag_o, 0);
      chk("fullA_num",  com_num_o, 1);
      chk("fullA_dpt0", dp_tag_o[5:0], 0);
      step();
      chk("fullB_free",  free_cnt_o, 1);
      chk("fullB_ready", dp_ready_o, 0);
      chk("fullB_dpt0",  dp_tag_o[5:0], 0);
      chk("fullB_cv",    com_valid_o, 0);
      dp_valid_i = 2'b11;
      step();
      chk("fullC_free", free_cnt_o, 1);
      chk("fullC_dpt0", dp_tag_o[5:0], 0);
      dp_valid_i = 2'b01;
      step();
      idle_in();
      chk("fullD_free", free_cnt_o, 0);
      chk("fullD_dpt0", dp_tag_o[5:0], 1);

      // Head at 63: commit pair straddles the wrap
      do_reset();
      dp_valid_i = 2'b11; dp_dstvalid_i = 2'b11;
      for (int i = 0; i < 31; i++) step();
      idle_in();
      for (int i = 0; i < 31; i++) begin
         fin_valid_i = 5'b00011; ftag[0] = 6'(2*i); ftag[1] = 6'(2*i + 1);
         step();
      end
      idle_in();
      step();
      chk("drain_free", free_cnt_o, 64);
      dp_valid_i = 2'b01; dp_dstvalid_i = 2'b01;
      step();
      idle_in();
      fin_valid_i = 5'b00001; ftag[0] = 62;
      step();
      idle_in();
      step();
      chk("h63_free", free_cnt_o, 64);
      chk("h63_dpt",  dp_tag_o, {6'd0, 6'd63});
      dp_valid_i = 2'b11; dp_dstvalid_i = 2'b11; dp_dst_i = {5'd11, 5'd10};
      step();
      idle_in();
      chk("h63_free2", free_cnt_o, 62);
      chk("h63_dpt0",  dp_tag_o[5:0], 1);
      fin_valid_i = 5'b00011; ftag[0] = 0; ftag[1] = 63;
      step();
      idle_in();
      chk("wrap_cv",   com_valid_o, 2'b11);
      chk("wrap_ctag", com_tag_o, {6'd0, 6'd63});
      chk("wrap_num",  com_num_o, 2);
      chk("wrap_dst",  com_dst_o, {5'd11, 5'd10});
      step();
      chk("wrap_free", free_cnt_o, 64);
      chk("wrap_cv2",  com_valid_o, 0);
      chk("wrap_dpt0", dp_tag_o[5:0], 1);

`ifdef ROB_FLUSH_EN
      // Flush to tag 2 with a concurrent dispatch
      do_reset();
      dp_valid_i = 2'b11; dp_dstvalid_i = 2'b11;
      repeat (3) step();
      flush_i = 1'b1; flush_tag_i = 2;
      step();
      idle_in();
      chk("fl_free", free_cnt_o, 61);
      chk("fl_dpt0", dp_tag_o[5:0], 3);
      fin_valid_i = 5'b01111; ftag[0] = 4; ftag[1] = 0; ftag[2] = 1; ftag[3] = 2;
      step();
      idle_in();
      chk("fl_cv1",  com_valid_o, 2'b11);
      chk("fl_tag1", com_tag_o, {6'd1, 6'd0});
      step();
      chk("fl_cv2",  com_valid_o, 2'b01);
      chk("fl_tag2", com_tag_o, 2);
      chk("fl_free2", free_cnt_o, 63);
      step();
      chk("fl_cv3",   com_valid_o, 0);
      chk("fl_free3", free_cnt_o, 64);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
